adder_rr_sched: RTL
===================

// Module: adder_rr_sched
// PURPOSE
//  Round-robin scheduler that shares one adder_nbit instance (BIT_WIDTH wide) among NUM_REQ requesters.
//  Each granted request is a multi-precision add of WORDS*BIT_WIDTH-bit operands.
//  Operands are processed one word per cycle, LSW first, with the carry registered between words.
//  Sits between requester blocks and the shared adder; owns arbitration, sequencing, carry chaining and result assembly.
// PARAMETERS
//  BIT_WIDTH  4  width of shared adder_nbit datapath (one word)
//  WORDS      2  words per operand; operand width OPW = WORDS*BIT_WIDTH; WORDS >= 1
//  NUM_REQ    3  number of requesters; NUM_REQ >= 2; IDW = $clog2(NUM_REQ)
// PORTS
//  clk       in   1              system clock, rising edge
//  n_rst     in   1              synchronous active-low reset
//  req       in   NUM_REQ        level request per requester
//  op_a      in   NUM_REQ*OPW    operand A; requester i occupies bits [i*OPW +: OPW]
//  op_b      in   NUM_REQ*OPW    operand B; same packing as op_a
//  grant     out  NUM_REQ        one-hot; high for the winner during ADD
//  busy      out  1              high in ADD and DONE
//  done      out  1              1-cycle pulse; result valid
//  done_id   out  IDW            index of the requester being answered
//  result    out  OPW            assembled sum
//  overflow  out  1              carry out of the most-significant word
// BEHAVIOUR
//  - Reset (n_rst=0 sampled at clk edge; this is the only reset):
//    - state=IDLE; all outputs 0; carry reg 0; word_cnt 0.
//    - rr_last=NUM_REQ-1, so requester 0 wins first.
//  - FSM states: IDLE, ADD, DONE.
//  - IDLE:
//    - If req!=0, pick the first asserted req at or after index rr_last+1 (mod NUM_REQ), scanning upward with wrap.
//    - On that edge: latch winner, its op_a/op_b slices and rr_last=winner; clear carry and word_cnt; -> ADD.
//    - If req==0: stay in IDLE.
//  - ADD (exactly WORDS cycles):
//    - grant[winner]=1.
//    - Adder inputs: a=A word[word_cnt], b=B word[word_cnt], carry_in=carry reg.
//    - Each edge: result word[word_cnt] <= sum; carry reg <= carry_out; word_cnt++.
//    - After word WORDS-1: overflow <= carry_out; -> DONE.
//  - DONE (1 cycle):
//    - done=1, done_id=winner, grant=0, busy=1; -> IDLE unconditionally.
//  - Latency: capture edge -> done high WORDS+1 cycles later.
//  - Back-to-back ops: minimum WORDS+2 cycles apart (one IDLE cycle).
//  - req is sampled only in IDLE. Dropping or changing req or operands during ADD/DONE has no effect; the op completes on latched operands.
//  - The requester must drop req in its done cycle. If req is still high in IDLE, it is treated as a new request.
//  - result and overflow change during ADD. They are valid when done=1 and held until the next capture edge.
//  - Reset mid-ADD or in DONE: op aborted, no done pulse, all state as reset.
//  - Arithmetic: unsigned modulo 2^OPW; carry_in of word 0 is always 0.
// CONFIGURATION
//  - Macro ADDER_RR_SCHED_SAT_EN defined: on entering DONE with final carry=1, result is forced to all ones; overflow still reads 1.
//  - Macro not defined: result is the wrapped sum.
// TESTING (BIT_WIDTH=4, WORDS=2, NUM_REQ=3)
//  1. Hold n_rst=0 two cycles with req=3'b111 -> grant=0, done=0, result=0, overflow=0, busy=0.
//  2. req=3'b010, A1=8'h0F, B1=8'h01 -> grant=3'b010 for 2 cycles, then done=1, done_id=1, result=8'h10, overflow=0 (inter-word carry).
//  3. req0 only, A0=8'hFF, B0=8'h01 -> result=8'h00, overflow=1; with ADDER_RR_SCHED_SAT_EN: result=8'hFF, overflow=1.
//  4. req=3'b111 held; each requester drops req in its done cycle and re-raises it next cycle -> done_id order 0,1,2,0; each done 4 cycles apart.
//  5. n_rst=0 in second ADD cycle -> no done pulse, outputs 0; then req2 with A2=8'h01, B2=8'h01 -> grant=3'b100, result=8'h02 (carry cleared).
//  6. req1 dropped in first ADD cycle, operands changed -> op still completes, done_id=1, result from operands latched at capture.

Source files
------------

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one adder_nbit among NUM_REQ requesters.
// Each granted request is a multi-word add processed LSW first, one word per
// cycle, with the carry registered between words.
// Optional feature: define ADDER_RR_SCHED_SAT_EN to saturate the result to all
// ones when the final carry out is set (overflow still reads 1).

// Shared single-word adder with carry in/out
module adder_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};

endmodule

module adder_rr_sched #(
  parameter  int BIT_WIDTH = 4,
  parameter  int WORDS     = 2,
  parameter  int NUM_REQ   = 3,
  localparam int OPW       = WORDS * BIT_WIDTH,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*OPW-1:0] op_a,
  input  logic [NUM_REQ*OPW-1:0] op_b,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   done,
  output logic [IDW-1:0]         done_id,
  output logic [OPW-1:0]         result,
  output logic                   overflow
);

  localparam int CNTW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t              state_q,    state_d;
  logic [IDW-1:0]      winner_q,   winner_d;
  logic [IDW-1:0]      rr_last_q,  rr_last_d;
  logic [OPW-1:0]      a_q,        a_d;
  logic [OPW-1:0]      b_q,        b_d;
  logic                carry_q,    carry_d;
  logic [CNTW-1:0]     word_cnt_q, word_cnt_d;
  logic [OPW-1:0]      result_q,   result_d;
  logic                overflow_q, overflow_d;
  logic [NUM_REQ-1:0]  grant_q,    grant_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic [IDW-1:0]      done_id_q,  done_id_d;

  logic                pick_found;
  logic [IDW-1:0]      pick_idx;
  logic [BIT_WIDTH-1:0] word_a;
  logic [BIT_WIDTH-1:0] word_b;
  logic [BIT_WIDTH-1:0] word_sum;
  logic                word_cout;
  logic                last_word;

  // Round-robin pick: first asserted request after rr_last, scanning upward with wrap
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_last_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'(idx);
      end
    end
  end

  // Select the current operand words feeding the shared adder
  always_comb begin
    int word_base;
    word_base = int'(word_cnt_q) * BIT_WIDTH;
    word_a    = a_q[word_base +: BIT_WIDTH];
    word_b    = b_q[word_base +: BIT_WIDTH];
    last_word = (word_cnt_q == CNTW'(WORDS - 1));
  end

  adder_nbit #(
    .BIT_WIDTH (BIT_WIDTH)
  ) u_adder (
    .a         (word_a),
    .b         (word_b),
    .carry_in  (carry_q),
    .sum       (word_sum),
    .carry_out (word_cout)
  );

  // Next-state logic: capture in IDLE, chain words in ADD, pulse done in DONE
  always_comb begin
    int word_base;
    int pick_base;
    state_d    = state_q;
    winner_d   = winner_q;
    rr_last_d  = rr_last_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    word_cnt_d = word_cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    word_base  = int'(word_cnt_q) * BIT_WIDTH;
    pick_base  = int'(pick_idx) * OPW;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          winner_d   = pick_idx;
          rr_last_d  = pick_idx;
          a_d        = op_a[pick_base +: OPW];
          b_d        = op_b[pick_base +: OPW];
          carry_d    = 1'b0;
          word_cnt_d = '0;
          grant_d    = NUM_REQ'(1) << pick_idx;
          busy_d     = 1'b1;
          state_d    = ADD;
        end
      end

      ADD: begin
        result_d[word_base +: BIT_WIDTH] = word_sum;
        carry_d    = word_cout;
        word_cnt_d = word_cnt_q + CNTW'(1);
        if (last_word) begin
          overflow_d = word_cout;
`ifdef ADDER_RR_SCHED_SAT_EN
          if (word_cout) begin
            result_d = '1;
          end
`endif
          word_cnt_d = '0;
          grant_d    = '0;
          done_d     = 1'b1;
          done_id_d  = winner_q;
          state_d    = DONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      winner_q   <= '0;
      rr_last_q  <= IDW'(NUM_REQ - 1);
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      word_cnt_q <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      rr_last_q  <= rr_last_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      word_cnt_q <= word_cnt_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign done_id  = done_id_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule
